id_ex_stage: RTL and testbench

ID/EX pipeline register with integrated hazard detection for the 5-stage MIPS pipeline. It captures decoded ID-stage values and feeds the EX stage, including the EX-stage forwarding unit, which consumes `ex_instru` and the register-write fields. It detects load-use and branch-operand hazards. When one is found it stalls PC and IF/ID and inserts a bubble into EX. A saturating stall-cycle counter is provided for performance debug.

---
 rtl/id_ex_stage.sv | 98 +++++++++
 tb/tb_id_ex_stage.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage MIPS pipeline, with load-use and
// branch-operand hazard detection and a saturating stall-cycle counter.
module id_ex_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      id_instru,
  input  logic [31:0]      id_pc4,
  input  logic [31:0]      id_rdata1,
  input  logic [31:0]      id_rdata2,
  input  logic [31:0]      id_imm,
  input  logic [7:0]       id_ctrl,
  input  logic             id_branch,
  input  logic             id_flush,
  input  logic             mem_MemRead,
  input  logic [4:0]       mem_wReg,
  output logic [31:0]      ex_instru,
  output logic [31:0]      ex_pc4,
  output logic [31:0]      ex_rdata1,
  output logic [31:0]      ex_rdata2,
  output logic [31:0]      ex_imm,
  output logic [7:0]       ex_ctrl,
  output logic [4:0]       ex_wReg,
  output logic             c_pc_write,
  output logic             c_ifid_write,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  logic       m_ex;
  logic       m_mem;
  logic       load_use;
  logic       branch_after_alu;
  logic       branch_after_load;
  logic       bubble;
  logic [4:0] wreg_next;

  assign rs = id_instru[25:21];
  assign rt = id_instru[20:16];
  assign rd = id_instru[15:11];

  // $0 is hardwired to zero, so a write to it can never create a dependence.
  assign m_ex  = (ex_wReg != 5'd0)  && ((ex_wReg == rs)  || (ex_wReg == rt));
  assign m_mem = (mem_wReg != 5'd0) && ((mem_wReg == rs) || (mem_wReg == rt));

  assign load_use          = ex_ctrl[5] && m_ex;
  assign branch_after_alu  = id_branch && ex_ctrl[7] && m_ex;
  assign branch_after_load = id_branch && mem_MemRead && m_mem;

  assign stall        = !id_flush && (load_use || branch_after_alu || branch_after_load);
  assign c_pc_write   = !stall;
  assign c_ifid_write = !stall;

  assign bubble    = id_flush || stall;
  assign wreg_next = id_ctrl[2] ? rd : rt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_instru <= '0;
      ex_pc4    <= '0;
      ex_rdata1 <= '0;
      ex_rdata2 <= '0;
      ex_imm    <= '0;
      ex_ctrl   <= '0;
      ex_wReg   <= '0;
    end else if (bubble) begin
      ex_instru <= '0;
      ex_pc4    <= '0;
      ex_rdata1 <= '0;
      ex_rdata2 <= '0;
      ex_imm    <= '0;
      ex_ctrl   <= '0;
      ex_wReg   <= '0;
    end else begin
      ex_instru <= id_instru;
      ex_pc4    <= id_pc4;
      ex_rdata1 <= id_rdata1;
      ex_rdata2 <= id_rdata2;
      ex_imm    <= id_imm;
      ex_ctrl   <= id_ctrl;
      ex_wReg   <= wreg_next;
    end
  end

  // Counter saturates at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage: hazard stalls, bubbles, flush overlap,
// counter saturation (second instance with a 4-bit counter) and reset mid-stall.
module tb_id_ex_stage;

  localparam logic [31:0] LW_R2    = 32'h8C02_0000;
  localparam logic [31:0] LW_R5    = 32'h8C05_0000;
  localparam logic [31:0] LW_R0    = 32'h8C00_0000;
  localparam logic [31:0] ADD_324  = 32'h0044_1820;
  localparam logic [31:0] ADD_100  = 32'h0000_0820;
  localparam logic [31:0] ADD_712  = 32'h0022_3820;
  localparam logic [31:0] SUB_877  = 32'h00E7_4022;
  localparam logic [31:0] ADD_9    = 32'h0000_4820;
  localparam logic [31:0] BEQ_56   = 32'h10A6_0000;
  localparam logic [31:0] BEQ_70   = 32'h10E0_0000;
  localparam logic [7:0]  CTRL_LW  = 8'h68;
  localparam logic [7:0]  CTRL_R   = 8'h86;
  localparam logic [7:0]  CTRL_BEQ = 8'h01;

  logic        clk;
  logic        rst_n;
  logic [31:0] id_instru;
  logic [31:0] id_pc4;
  logic [31:0] id_rdata1;
  logic [31:0] id_rdata2;
  logic [31:0] id_imm;
  logic [7:0]  id_ctrl;
  logic        id_branch;
  logic        id_flush;
  logic        mem_MemRead;
  logic [4:0]  mem_wReg;
  logic [31:0] ex_instru;
  logic [31:0] ex_pc4;
  logic [31:0] ex_rdata1;
  logic [31:0] ex_rdata2;
  logic [31:0] ex_imm;
  logic [7:0]  ex_ctrl;
  logic [4:0]  ex_wReg;
  logic        c_pc_write;
  logic        c_ifid_write;
  logic        stall;
  logic [15:0] stall_cnt;

  logic [31:0] s_instru;
  logic [31:0] s_pc4;
  logic [31:0] s_rdata1;
  logic [31:0] s_rdata2;
  logic [31:0] s_imm;
  logic [7:0]  s_ctrl;
  logic [4:0]  s_wReg;
  logic        s_pc_write;
  logic        s_ifid_write;
  logic        s_stall;
  logic [3:0]  s_cnt;

  int checks = 0;
  int errors = 0;

  id_ex_stage #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_instru(id_instru), .id_pc4(id_pc4), .id_rdata1(id_rdata1),
    .id_rdata2(id_rdata2), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .id_branch(id_branch), .id_flush(id_flush),
    .mem_MemRead(mem_MemRead), .mem_wReg(mem_wReg),
    .ex_instru(ex_instru), .ex_pc4(ex_pc4), .ex_rdata1(ex_rdata1),
    .ex_rdata2(ex_rdata2), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
    .ex_wReg(ex_wReg), .c_pc_write(c_pc_write), .c_ifid_write(c_ifid_write),
    .stall(stall), .stall_cnt(stall_cnt)
  );

  id_ex_stage #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .id_instru(id_instru), .id_pc4(id_pc4), .id_rdata1(id_rdata1),
    .id_rdata2(id_rdata2), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .id_branch(id_branch), .id_flush(id_flush),
    .mem_MemRead(mem_MemRead), .mem_wReg(mem_wReg),
    .ex_instru(s_instru), .ex_pc4(s_pc4), .ex_rdata1(s_rdata1),
    .ex_rdata2(s_rdata2), .ex_imm(s_imm), .ex_ctrl(s_ctrl),
    .ex_wReg(s_wReg), .c_pc_write(s_pc_write), .c_ifid_write(s_ifid_write),
    .stall(s_stall), .stall_cnt(s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1ns after a rising edge, so checks made here see settled logic.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [31:0] instru, input logic [7:0] ctrl,
                        input logic branch, input logic [31:0] pc4);
    id_instru = instru;
    id_ctrl   = ctrl;
    id_branch = branch;
    id_pc4    = pc4;
    id_rdata1 = pc4 ^ 32'h1111_0000;
    id_rdata2 = pc4 ^ 32'h2222_0000;
    id_imm    = pc4 ^ 32'h3333_0000;
    #1;
  endtask

  task automatic do_reset();
    set_id(32'h0, 8'h0, 1'b0, 32'h0);
    id_flush    = 1'b0;
    mem_MemRead = 1'b0;
    mem_wReg    = 5'd0;
    rst_n       = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    set_id(ADD_324, CTRL_R, 1'b0, 32'h0000_0400);
    rst_n = 1'b0;
    step();
    checks++;
    if (ex_instru !== 32'h0 || ex_ctrl !== 8'h0 || ex_wReg !== 5'd0 || ex_pc4 !== 32'h0 ||
        ex_rdata1 !== 32'h0 || ex_rdata2 !== 32'h0 || ex_imm !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_ex: instru=%h ctrl=%h wreg=%0d pc4=%h want all zero",
               ex_instru, ex_ctrl, ex_wReg, ex_pc4);
    end
    checks++;
    if (stall_cnt !== 16'd0 || stall !== 1'b0 || c_pc_write !== 1'b1 || c_ifid_write !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_ctl: cnt=%0d stall=%b pcw=%b ifidw=%b want 0 0 1 1",
               stall_cnt, stall, c_pc_write, c_ifid_write);
    end
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(LW_R2, CTRL_LW, 1'b0, 32'h0000_0100);
    step();
    checks++;
    if (ex_ctrl !== CTRL_LW || ex_wReg !== 5'd2 || ex_pc4 !== 32'h0000_0100 ||
        ex_imm !== 32'h3333_0100) begin
      errors++;
      $display("[TB] FAIL lu_load: ctrl=%h wreg=%0d pc4=%h imm=%h want 68 2 00000100 33330100",
               ex_ctrl, ex_wReg, ex_pc4, ex_imm);
    end
    set_id(ADD_324, CTRL_R, 1'b0, 32'h0000_0104);
    checks++;
    if (stall !== 1'b1 || c_pc_write !== 1'b0 || c_ifid_write !== 1'b0) begin
      errors++;
      $display("[TB] FAIL lu_stall: stall=%b pcw=%b ifidw=%b want 1 0 0", stall, c_pc_write, c_ifid_write);
    end
    step();
    checks++;
    if (ex_ctrl !== 8'h0 || ex_instru !== 32'h0 || ex_pc4 !== 32'h0 || ex_rdata1 !== 32'h0 ||
        stall !== 1'b0 || c_pc_write !== 1'b1) begin
      errors++;
      $display("[TB] FAIL lu_bubble: ctrl=%h instru=%h pc4=%h stall=%b want 0 0 0 0",
               ex_ctrl, ex_instru, ex_pc4, stall);
    end
    step();
    checks++;
    if (ex_instru !== ADD_324 || ex_wReg !== 5'd3 || stall_cnt !== 16'd1 ||
        ex_rdata2 !== 32'h2222_0104) begin
      errors++;
      $display("[TB] FAIL lu_resume: instru=%h wreg=%0d cnt=%0d rdata2=%h want %h 3 1 22220104",
               ex_instru, ex_wReg, stall_cnt, ex_rdata2, ADD_324);
    end
  endtask

  task automatic test_branch_after_load();
    do_reset();
    set_id(LW_R5, CTRL_LW, 1'b0, 32'h0000_0200);
    step();
    set_id(BEQ_56, CTRL_BEQ, 1'b1, 32'h0000_0204);
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bal_cyc1: stall=%b want 1", stall);
    end
    step();
    mem_MemRead = 1'b1;
    mem_wReg    = 5'd5;
    #1;
    checks++;
    if (stall !== 1'b1 || ex_ctrl !== 8'h0 || c_ifid_write !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bal_cyc2: stall=%b ctrl=%h ifidw=%b want 1 00 0", stall, ex_ctrl, c_ifid_write);
    end
    step();
    mem_MemRead = 1'b0;
    mem_wReg    = 5'd0;
    #1;
    checks++;
    if (stall !== 1'b0 || stall_cnt !== 16'd2 || ex_instru !== 32'h0) begin
      errors++;
      $display("[TB] FAIL bal_clear: stall=%b cnt=%0d instru=%h want 0 2 0", stall, stall_cnt, ex_instru);
    end
    step();
    checks++;
    if (ex_instru !== BEQ_56 || ex_ctrl !== CTRL_BEQ || ex_wReg !== 5'd6 || stall_cnt !== 16'd2) begin
      errors++;
      $display("[TB] FAIL bal_load: instru=%h ctrl=%h wreg=%0d cnt=%0d want %h 01 6 2",
               ex_instru, ex_ctrl, ex_wReg, stall_cnt, BEQ_56);
    end
  endtask

  task automatic test_no_hazard();
    do_reset();
    set_id(LW_R0, CTRL_LW, 1'b0, 32'h0000_0300);
    step();
    set_id(ADD_100, CTRL_R, 1'b0, 32'h0000_0304);
    mem_MemRead = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0 || ex_ctrl !== CTRL_LW) begin
      errors++;
      $display("[TB] FAIL r0_nostall: stall=%b ctrl=%h want 0 68", stall, ex_ctrl);
    end
    mem_MemRead = 1'b0;
    set_id(ADD_712, CTRL_R, 1'b0, 32'h0000_0308);
    step();
    checks++;
    if (ex_wReg !== 5'd7) begin
      errors++;
      $display("[TB] FAIL alu_wreg: wreg=%0d want 7", ex_wReg);
    end
    set_id(SUB_877, CTRL_R, 1'b0, 32'h0000_030C);
    checks++;
    if (stall !== 1'b0 || c_pc_write !== 1'b1) begin
      errors++;
      $display("[TB] FAIL alu_nostall: stall=%b pcw=%b want 0 1", stall, c_pc_write);
    end
    set_id(ADD_9, CTRL_R, 1'b0, 32'h0000_0310);
    step();
    checks++;
    if (ex_wReg !== 5'd9 || ex_instru !== ADD_9) begin
      errors++;
      $display("[TB] FAIL regdst_wreg: wreg=%0d instru=%h want 9 %h", ex_wReg, ex_instru, ADD_9);
    end
  endtask

  task automatic test_branch_after_alu();
    do_reset();
    set_id(ADD_712, CTRL_R, 1'b0, 32'h0000_0500);
    step();
    set_id(BEQ_70, CTRL_BEQ, 1'b1, 32'h0000_0504);
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("[TB] FAIL baa_stall: stall=%b want 1", stall);
    end
    step();
    checks++;
    if (stall !== 1'b0 || ex_ctrl !== 8'h0 || stall_cnt !== 16'd1) begin
      errors++;
      $display("[TB] FAIL baa_clear: stall=%b ctrl=%h cnt=%0d want 0 00 1", stall, ex_ctrl, stall_cnt);
    end
    step();
    checks++;
    if (ex_instru !== BEQ_70) begin
      errors++;
      $display("[TB] FAIL baa_load: instru=%h want %h", ex_instru, BEQ_70);
    end
  endtask

  task automatic test_flush_overlap();
    do_reset();
    set_id(LW_R2, CTRL_LW, 1'b0, 32'h0000_0600);
    step();
    set_id(ADD_324, CTRL_R, 1'b0, 32'h0000_0604);
    id_flush = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0 || c_pc_write !== 1'b1 || c_ifid_write !== 1'b1) begin
      errors++;
      $display("[TB] FAIL flush_ctl: stall=%b pcw=%b ifidw=%b want 0 1 1", stall, c_pc_write, c_ifid_write);
    end
    step();
    id_flush = 1'b0;
    #1;
    checks++;
    if (ex_ctrl !== 8'h0 || ex_instru !== 32'h0 || ex_pc4 !== 32'h0 || stall_cnt !== 16'd0) begin
      errors++;
      $display("[TB] FAIL flush_bubble: ctrl=%h instru=%h pc4=%h cnt=%0d want 0 0 0 0",
               ex_ctrl, ex_instru, ex_pc4, stall_cnt);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    set_id(BEQ_56, CTRL_BEQ, 1'b1, 32'h0000_0700);
    mem_MemRead = 1'b1;
    mem_wReg    = 5'd5;
    #1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 14 || i == 15 || i == 20) begin
        checks++;
        if (s_cnt !== ((i >= 15) ? 4'hF : 4'(i))) begin
          errors++;
          $display("[TB] FAIL sat_cnt%0d: cnt=%h want %h", i, s_cnt, (i >= 15) ? 4'hF : 4'(i));
        end
      end
    end
    checks++;
    if (stall_cnt !== 16'd20 || s_stall !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sat_wide: cnt=%0d stall=%b want 20 1", stall_cnt, s_stall);
    end
    mem_MemRead = 1'b0;
    mem_wReg    = 5'd0;
    #1;
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    set_id(LW_R5, CTRL_LW, 1'b0, 32'h0000_0800);
    step();
    set_id(BEQ_56, CTRL_BEQ, 1'b1, 32'h0000_0804);
    step();
    mem_MemRead = 1'b1;
    mem_wReg    = 5'd5;
    rst_n       = 1'b0;
    #1;
    step();
    rst_n       = 1'b1;
    mem_MemRead = 1'b0;
    mem_wReg    = 5'd0;
    #1;
    checks++;
    if (ex_instru !== 32'h0 || ex_ctrl !== 8'h0 || ex_wReg !== 5'd0 || ex_pc4 !== 32'h0 ||
        ex_imm !== 32'h0 || stall_cnt !== 16'd0) begin
      errors++;
      $display("[TB] FAIL rms_zero: instru=%h ctrl=%h wreg=%0d cnt=%0d want 0 0 0 0",
               ex_instru, ex_ctrl, ex_wReg, stall_cnt);
    end
    checks++;
    if (stall !== 1'b0 || c_pc_write !== 1'b1 || c_ifid_write !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rms_enables: stall=%b pcw=%b ifidw=%b want 0 1 1", stall, c_pc_write, c_ifid_write);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    id_flush    = 1'b0;
    mem_MemRead = 1'b0;
    mem_wReg    = 5'd0;
    id_instru   = 32'h0;
    id_ctrl     = 8'h0;
    id_branch   = 1'b0;
    id_pc4      = 32'h0;
    id_rdata1   = 32'h0;
    id_rdata2   = 32'h0;
    id_imm      = 32'h0;
    #1;
    test_reset();
    test_load_use();
    test_branch_after_load();
    test_no_hazard();
    test_branch_after_alu();
    test_flush_overlap();
    test_saturation();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
